// File: rtl/multi_chan_trig.sv
// Multi-channel edge/level trigger with AND/OR combining, match-length qualifier
// and an idle/armed/triggered control FSM.
module multi_chan_trig #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MATCH_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                disarm,
    input  logic [NUM_CH-1:0]   ch_h,
    input  logic [NUM_CH-1:0]   ch_l,
    input  logic [5*NUM_CH-1:0] trig_cfg,
    input  logic                or_mode,
    input  logic [MATCH_W-1:0]  match_len,
    output logic                armed,
    output logic                triggered,
    output logic                trig_pulse,
    output logic [NUM_CH-1:0]   ch_match
);

    typedef enum logic [1:0] {StIdle, StArmed, StTriggered} state_e;

    state_e             state_q, state_d;
    logic [NUM_CH-1:0]  h_q, h_qq, l_q, l_qq;
    logic [NUM_CH-1:0]  eh_q, eh_d, el_q, el_d;
    logic [NUM_CH-1:0]  rise_h, rise_l;
    logic [MATCH_W-1:0] cnt_q, cnt_d;
    logic [MATCH_W:0]   cnt_inc, eff_len;
    logic               pulse_q, pulse_d;
    logic               cond, fire;

    assign rise_h = h_q & ~h_qq;
    assign rise_l = l_q & ~l_qq;

    // cfg0 is a forced match in AND mode only.
    always_comb begin
        ch_match = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_match[i] = (trig_cfg[5*i+4] & (eh_q[i] | rise_h[i]))
                        | (trig_cfg[5*i+3] & (el_q[i] | rise_l[i]))
                        | (trig_cfg[5*i+2] & h_q[i])
                        | (trig_cfg[5*i+1] & l_q[i])
                        | (~or_mode & trig_cfg[5*i]);
        end
    end

    assign cond    = or_mode ? |ch_match : &ch_match;
    assign eff_len = (match_len == '0) ? (MATCH_W+1)'(1) : {1'b0, match_len};
    assign cnt_inc = {1'b0, cnt_q} + (MATCH_W+1)'(1);
    assign fire    = cond && (cnt_inc >= eff_len);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            h_q     <= '0;
            h_qq    <= '0;
            l_q     <= '0;
            l_qq    <= '0;
            eh_q    <= '0;
            el_q    <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= ch_h;
            h_qq    <= h_q;
            l_q     <= ch_l;
            l_qq    <= l_q;
            eh_q    <= eh_d;
            el_q    <= el_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Disarm has priority; arm while armed restarts without triggering.
    always_comb begin
        state_d = state_q;
        if (disarm) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:      if (arm) state_d = StArmed;
                StArmed:     if (!arm && fire) state_d = StTriggered;
                StTriggered: if (arm) state_d = StArmed;
                default:     state_d = StIdle;
            endcase
        end
    end

    // Count and sticky flags; count defaults to zero outside a qualifying run.
    always_comb begin
        eh_d    = eh_q;
        el_d    = el_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (arm || disarm) begin
            eh_d = '0;
            el_d = '0;
        end else if (state_q == StArmed) begin
            eh_d = eh_q | rise_h;
            el_d = el_q | rise_l;
            if (fire) begin
                pulse_d = 1'b1;
            end else if (cond) begin
                cnt_d = cnt_inc[MATCH_W-1:0];
            end
        end
    end

    always_comb begin
        armed      = (state_q == StArmed);
        triggered  = (state_q == StTriggered);
        trig_pulse = pulse_q;
    end

endmodule

// File: tb/tb_multi_chan_trig.sv
// Bench for multi_chan_trig: expected {armed,triggered,trig_pulse} per cycle go
// through a scoreboard queue; ch_match is checked at selected points.
module tb_multi_chan_trig;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned MATCH_W = 8;

    logic                clk = 1'b0;
    logic                rst_n, arm, disarm, or_mode;
    logic [NUM_CH-1:0]   ch_h, ch_l, ch_match;
    logic [5*NUM_CH-1:0] trig_cfg;
    logic [MATCH_W-1:0]  match_len;
    logic                armed, triggered, trig_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];

    multi_chan_trig #(.NUM_CH(NUM_CH), .MATCH_W(MATCH_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (arm),
        .disarm     (disarm),
        .ch_h       (ch_h),
        .ch_l       (ch_l),
        .trig_cfg   (trig_cfg),
        .or_mode    (or_mode),
        .match_len  (match_len),
        .armed      (armed),
        .triggered  (triggered),
        .trig_pulse (trig_pulse),
        .ch_match   (ch_match)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] cfg4(input logic [4:0] c0, input logic [4:0] c1,
                                         input logic [4:0] c2, input logic [4:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        arm    = 1'b0;
        disarm = 1'b0;
        ch_h   = '0;
        ch_l   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] e;
        trig_cfg  = cfg4(5'b10000, 5'b00001, 5'b00100, 5'b00001);
        or_mode   = 1'b0;
        match_len = 8'd1;
        rst_n     = 1'b0;
        arm       = 1'b1;
        disarm    = 1'b0;
        ch_h      = 4'hF;
        ch_l      = 4'hF;
        exp_q.push_back(3'b000);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if ({armed, triggered, trig_pulse} !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", {armed, triggered, trig_pulse}, e);
        end
        n_checks++;
        if (ch_match !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_ch_match_and: got %b expected 1010", ch_match);
        end
        or_mode = 1'b1;
        #1;
        n_checks++;
        if (ch_match !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ch_match_or: got %b expected 0000", ch_match);
        end
        or_mode = 1'b0;
        arm     = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_and_edge();
        logic [2:0] e;
        do_reset();
        trig_cfg  = cfg4(5'b10000, 5'b00001, 5'b00001, 5'b00001);
        or_mode   = 1'b0;
        match_len = 8'd1;
        for (int c = 0; c < 8; c++) begin
            arm  = (c == 0);
            ch_h = (c >= 2) ? 4'b0001 : 4'b0000;
            exp_q.push_back((c <= 2) ? 3'b100 : (c == 3) ? 3'b011 : 3'b010);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({armed, triggered, trig_pulse} !== e) begin
                n_fail++;
                $display("FAIL and_edge cyc %0d: got %b expected %b", c,
                         {armed, triggered, trig_pulse}, e);
            end
        end
    endtask

    task automatic test_sticky();
        logic [2:0] e;
        do_reset();
        trig_cfg  = cfg4(5'b10000, 5'b00100, 5'b00001, 5'b00001);
        or_mode   = 1'b0;
        match_len = 8'd1;
        for (int c = 0; c < 33; c++) begin
            arm    = (c == 0) || (c == 17) || (c == 21);
            disarm = (c == 16) || (c == 20);
            ch_h   = (c == 1 || c == 18) ? 4'b0001 :
                     ((c >= 13 && c <= 15) || c >= 22) ? 4'b0010 : 4'b0000;
            exp_q.push_back((c == 14) ? 3'b011 : (c == 15) ? 3'b010 :
                            (c == 16 || c == 20) ? 3'b000 : 3'b100);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({armed, triggered, trig_pulse} !== e) begin
                n_fail++;
                $display("FAIL sticky cyc %0d: got %b expected %b", c,
                         {armed, triggered, trig_pulse}, e);
            end
        end
        n_checks++;
        if (ch_match !== 4'b1110) begin
            n_fail++;
            $display("FAIL sticky_cleared_match: got %b expected 1110", ch_match);
        end
    endtask

    task automatic test_qualifier();
        logic [2:0] e;
        do_reset();
        trig_cfg  = cfg4(5'b00100, 5'b00001, 5'b00001, 5'b00001);
        or_mode   = 1'b0;
        match_len = 8'd5;
        for (int c = 0; c < 15; c++) begin
            arm  = (c == 0);
            ch_h = ((c >= 1 && c <= 4) || c >= 8) ? 4'b0001 : 4'b0000;
            exp_q.push_back((c == 13) ? 3'b011 : (c == 14) ? 3'b010 : 3'b100);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({armed, triggered, trig_pulse} !== e) begin
                n_fail++;
                $display("FAIL qualifier cyc %0d: got %b expected %b", c,
                         {armed, triggered, trig_pulse}, e);
            end
        end
    endtask

    task automatic test_or_mode();
        logic [2:0] e;
        do_reset();
        trig_cfg  = cfg4(5'b00001, 5'b00001, 5'b00001, 5'b00001);
        or_mode   = 1'b1;
        match_len = 8'd1;
        ch_h      = 4'hF;
        ch_l      = 4'hF;
        for (int c = 0; c < 22; c++) begin
            arm = (c == 0);
            if (c == 20) begin
                n_checks++;
                if (ch_match !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL or_none_match: got %b expected 0000", ch_match);
                end
                trig_cfg = cfg4(5'b00001, 5'b00001, 5'b00010, 5'b00001);
                #1;
                n_checks++;
                if (ch_match !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL or_ch2_match: got %b expected 0100", ch_match);
                end
            end
            exp_q.push_back((c == 20) ? 3'b011 : (c == 21) ? 3'b010 : 3'b100);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({armed, triggered, trig_pulse} !== e) begin
                n_fail++;
                $display("FAIL or_mode cyc %0d: got %b expected %b", c,
                         {armed, triggered, trig_pulse}, e);
            end
        end
    endtask

    task automatic test_races();
        logic [2:0] e;
        do_reset();
        trig_cfg  = cfg4(5'b10000, 5'b00001, 5'b00001, 5'b00001);
        or_mode   = 1'b0;
        match_len = 8'd1;
        for (int c = 0; c < 29; c++) begin
            arm    = (c <= 2) || (c == 5) || (c == 13);
            disarm = (c == 1) || (c == 11);
            rst_n  = (c != 18);
            ch_h   = ((c >= 3 && c <= 10) || c >= 14) ? 4'b0001 : 4'b0000;
            if (c == 11) begin
                trig_cfg  = cfg4(5'b00100, 5'b00001, 5'b00001, 5'b00001);
                match_len = 8'd8;
            end
            exp_q.push_back((c == 1 || c == 11 || c == 12 || c >= 18) ? 3'b000 :
                            (c == 4) ? 3'b011 : 3'b100);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({armed, triggered, trig_pulse} !== e) begin
                n_fail++;
                $display("FAIL races cyc %0d: got %b expected %b", c,
                         {armed, triggered, trig_pulse}, e);
            end
            if (c == 10) begin
                n_checks++;
                if (ch_match !== 4'b1110) begin
                    n_fail++;
                    $display("FAIL rearm_flags_cleared: got %b expected 1110", ch_match);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_and_block();
        logic [2:0] e;
        do_reset();
        trig_cfg  = cfg4(5'b00000, 5'b00100, 5'b00100, 5'b00100);
        or_mode   = 1'b0;
        match_len = 8'd1;
        ch_h      = 4'hF;
        for (int c = 0; c < 101; c++) begin
            arm = (c == 0);
            exp_q.push_back(3'b100);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({armed, triggered, trig_pulse} !== e) begin
                n_fail++;
                $display("FAIL and_block cyc %0d: got %b expected %b", c,
                         {armed, triggered, trig_pulse}, e);
            end
        end
        n_checks++;
        if (ch_match !== 4'b1110) begin
            n_fail++;
            $display("FAIL and_block_match: got %b expected 1110", ch_match);
        end
    endtask

    initial begin
        test_reset();
        test_and_edge();
        test_sticky();
        test_qualifier();
        test_or_mode();
        test_races();
        test_and_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
